alu: RTL and testbench

- 16-bit registered ALU in the CPU execute stage.
- Each cycle it samples a 4-bit operation code and two register-file operands.
- It registers either an arithmetic/logic result into the accumulator, or a branch-taken decision for the PC logic.
- Single clock domain; asynchronous active-low reset.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_if.sv | 28 ++
 rtl/alu_cmp.sv | 14 +
 rtl/alu.sv | 124 ++++++++++++
 tb/tb_alu.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: default width, opcode encoding, shift width.
package alu_pkg;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_AND  = 4'h1,
        OP_OR   = 4'h2,
        OP_XOR  = 4'h3,
        OP_SUB  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ADD  = 4'h8,
        OP_PASS = 4'h9,
        OP_SRA  = 4'hA,
        OP_SLTU = 4'hB,
        OP_BEQ  = 4'hC,
        OP_BLT  = 4'hD,
        OP_BGT  = 4'hE,
        OP_BNE  = 4'hF
    } alu_op_e;

    function automatic logic is_branch(input alu_op_e op);
        logic [3:0] w_code;
        w_code = op;
        return (w_code[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operation/result bundle between the issue logic and the ALU.
// Optional status flags appear when ALU_FLAGS_EN is defined.
interface alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
);
    alu_op_e            alu_code;
    logic [WIDTH-1:0]   reg_data1;
    logic [WIDTH-1:0]   reg_data2;
    logic [WIDTH-1:0]   accum;
    logic               pc_branch;
`ifdef ALU_FLAGS_EN
    logic               zero_flag;
    logic               carry_flag;
    logic               ovf_flag;

    modport master (output alu_code, reg_data1, reg_data2,
                    input  accum, pc_branch, zero_flag, carry_flag, ovf_flag);
    modport slave  (input  alu_code, reg_data1, reg_data2,
                    output accum, pc_branch, zero_flag, carry_flag, ovf_flag);
`else
    modport master (output alu_code, reg_data1, reg_data2,
                    input  accum, pc_branch);
    modport slave  (input  alu_code, reg_data1, reg_data2,
                    output accum, pc_branch);
`endif
endinterface

// File: rtl/alu_cmp.sv
// Unsigned magnitude comparator shared by SLTU and the branch decode.
module alu_cmp #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_eq,
    output logic             o_ltu,
    output logic             o_gtu
);
    assign o_eq  = (i_a == i_b);
    assign o_ltu = (i_a <  i_b);
    assign o_gtu = (i_a >  i_b);
endmodule

// File: rtl/alu.sv
// Registered 16-bit execute-stage ALU producing an accumulator result or a branch decision.
// Define ALU_FLAGS_EN to add registered zero/carry/overflow flags.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    logic [WIDTH-1:0]        w_a;
    logic [WIDTH-1:0]        w_b;
    logic signed [WIDTH-1:0] w_a_s;
    logic [SHAMT_W-1:0]      w_shamt;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH:0]          w_diff;
    logic                    w_eq;
    logic                    w_ltu;
    logic                    w_gtu;
    logic [WIDTH-1:0]        w_result;
    logic                    w_branch;

    logic [WIDTH-1:0]        r_accum_p1;
    logic                    r_branch_p1;

    assign w_a     = bus.reg_data1;
    assign w_b     = bus.reg_data2;
    assign w_a_s   = w_a;
    assign w_shamt = w_b[SHAMT_W-1:0];
    // Extra MSB carries the ADD carry-out / SUB borrow.
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff  = {1'b0, w_a} - {1'b0, w_b};

    alu_cmp #(.WIDTH(WIDTH)) u_cmp (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_eq  (w_eq),
        .o_ltu (w_ltu),
        .o_gtu (w_gtu)
    );

    // Stage p0: result select; NOP and branch codes hold the accumulator.
    always_comb begin
        w_result = r_accum_p1;
        w_branch = 1'b0;
        case (bus.alu_code)
            OP_NOP:  w_result = r_accum_p1;
            OP_AND:  w_result = w_a & w_b;
            OP_OR:   w_result = w_a | w_b;
            OP_XOR:  w_result = w_a ^ w_b;
            OP_SUB:  w_result = w_diff[WIDTH-1:0];
            OP_NOT:  w_result = ~w_a;
            OP_SHL:  w_result = w_a << w_shamt;
            OP_SHR:  w_result = w_a >> w_shamt;
            OP_ADD:  w_result = w_sum[WIDTH-1:0];
            OP_PASS: w_result = w_b;
            OP_SRA:  w_result = w_a_s >>> w_shamt;
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_ltu};
            OP_BEQ:  w_branch = w_eq;
            OP_BLT:  w_branch = w_ltu;
            OP_BGT:  w_branch = w_gtu;
            OP_BNE:  w_branch = ~w_eq;
            default: w_result = r_accum_p1;
        endcase
    end

    // Stage p1: output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accum_p1  <= '0;
            r_branch_p1 <= 1'b0;
        end else begin
            r_accum_p1  <= w_result;
            r_branch_p1 <= w_branch;
        end
    end

    assign bus.accum     = r_accum_p1;
    assign bus.pc_branch = r_branch_p1;

`ifdef ALU_FLAGS_EN
    logic w_flag_upd;
    logic w_carry;
    logic w_ovf;
    logic r_zero_p1;
    logic r_carry_p1;
    logic r_ovf_p1;

    assign w_flag_upd = (bus.alu_code != OP_NOP) && !is_branch(bus.alu_code);

    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (bus.alu_code == OP_ADD) begin
            w_carry = w_sum[WIDTH];
            w_ovf   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
        end else if (bus.alu_code == OP_SUB) begin
            w_carry = w_diff[WIDTH];
            w_ovf   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_p1  <= 1'b0;
            r_carry_p1 <= 1'b0;
            r_ovf_p1   <= 1'b0;
        end else if (w_flag_upd) begin
            r_zero_p1  <= (w_result == '0);
            r_carry_p1 <= w_carry;
            r_ovf_p1   <= w_ovf;
        end
    end

    assign bus.zero_flag  = r_zero_p1;
    assign bus.carry_flag = r_carry_p1;
    assign bus.ovf_flag   = r_ovf_p1;
`else
    logic w_unused_carries;
    assign w_unused_carries = w_sum[WIDTH] ^ w_diff[WIDTH];
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed plan cases plus randomized ops checked
// against an integer-arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] acc;
        logic        br;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t q[$];

    int   m_acc;
    logic m_z, m_c, m_v;

    alu_if u_if ();

    alu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    // Reference model: updates architectural state and returns the expected outputs.
    function automatic exp_t model(input int code, input int a, input int b);
        exp_t e;
        int   sh;
        int   res;
        int   s;
        logic upd;
        logic c;
        logic v;
        sh  = b % 16;
        res = m_acc;
        upd = 1'b1;
        c   = 1'b0;
        v   = 1'b0;
        e.br = 1'b0;
        case (code)
            1:  res = a & b;
            2:  res = a | b;
            3:  res = a ^ b;
            4: begin
                res = (a - b) & 16'hFFFF;
                c   = (a < b);
                s   = to_signed16(a) - to_signed16(b);
                v   = (s > 32767) || (s < -32768);
            end
            5:  res = (~a) & 16'hFFFF;
            6:  res = (a << sh) & 16'hFFFF;
            7:  res = a >> sh;
            8: begin
                res = (a + b) & 16'hFFFF;
                c   = (a + b) > 65535;
                s   = to_signed16(a) + to_signed16(b);
                v   = (s > 32767) || (s < -32768);
            end
            9:  res = b;
            10: res = (to_signed16(a) >>> sh) & 16'hFFFF;
            11: res = (a < b) ? 1 : 0;
            12: begin upd = 1'b0; e.br = (a == b); end
            13: begin upd = 1'b0; e.br = (a < b);  end
            14: begin upd = 1'b0; e.br = (a > b);  end
            15: begin upd = 1'b0; e.br = (a != b); end
            default: upd = 1'b0;
        endcase
        m_acc = res;
        if (upd) begin
            m_z = (res == 0);
            m_c = c;
            m_v = v;
        end
        e.acc = res[15:0];
        e.z   = m_z;
        e.c   = m_c;
        e.v   = m_v;
        return e;
    endfunction

    task automatic do_op(input int code, input int a, input int b);
        @(negedge clk);
        u_if.alu_code  = alu_op_e'(code[3:0]);
        u_if.reg_data1 = a[15:0];
        u_if.reg_data2 = b[15:0];
        q.push_back(model(code, a, b));
    endtask

    // Monitor: one result per clock, sampled just after the active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("accum", int'(u_if.accum), int'(e.acc));
            check("pc_branch", int'(u_if.pc_branch), int'(e.br));
`ifdef ALU_FLAGS_EN
            check("zero_flag", int'(u_if.zero_flag), int'(e.z));
            check("carry_flag", int'(u_if.carry_flag), int'(e.c));
            check("ovf_flag", int'(u_if.ovf_flag), int'(e.v));
`endif
        end
    end

    function automatic int pick_operand();
        int sel;
        sel = $urandom_range(0, 4);
        case (sel)
            0: return 0;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 1;
        endcase
    endfunction

    initial begin
        int code, a, b, mode;
        n_checks = 0;
        n_fail   = 0;
        m_acc    = 0;
        m_z      = 1'b0;
        m_c      = 1'b0;
        m_v      = 1'b0;
        rst_n    = 1'b1;
        u_if.alu_code  = OP_NOP;
        u_if.reg_data1 = '0;
        u_if.reg_data2 = '0;

        // Asynchronous reset asserted between edges.
        #3 rst_n = 1'b0;
        #1;
        check("reset_accum", int'(u_if.accum), 0);
        check("reset_branch", int'(u_if.pc_branch), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 0, 0);
        do_op(0, 16'h1234, 16'h5678);

        // Directed plan cases.
        do_op(8, 16'h0001, 16'h003F);
        do_op(4, 16'h003F, 16'h0001);
        do_op(12, 1, 1);
        do_op(12, 1, 3);
        do_op(13, 1, 3);
        do_op(13, 3, 1);
        do_op(14, 1, 3);
        do_op(14, 3, 1);
        do_op(14, 5, 5);
        do_op(13, 5, 5);
        do_op(15, 5, 5);
        do_op(8, 16'hFFFF, 16'h0001);
        do_op(4, 16'h0000, 16'h0001);
        do_op(10, 16'h8000, 16'h0013);
        do_op(6, 16'h0001, 16'hFFFF);
        do_op(7, 16'h8000, 16'h0010);
        do_op(11, 2, 3);
        do_op(5, 16'h00FF, 0);
        do_op(9, 0, 16'hBEEF);
        do_op(0, 16'hFFFF, 16'hFFFF);

        // Reset mid-operation discards the in-flight ADD.
        @(posedge clk);
        #2;
        u_if.alu_code  = OP_ADD;
        u_if.reg_data1 = 16'h0011;
        u_if.reg_data2 = 16'h0022;
        #1 rst_n = 1'b0;
        #1;
        check("midreset_accum", int'(u_if.accum), 0);
        check("midreset_branch", int'(u_if.pc_branch), 0);
        m_acc = 0;
        m_z   = 1'b0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        u_if.alu_code = OP_NOP;
        rst_n = 1'b1;
        do_op(0, 16'h0011, 16'h0022);

        // Randomized traffic with biased operands.
        for (int i = 0; i < 400; i++) begin
            code = $urandom_range(0, 15);
            mode = $urandom_range(0, 3);
            a    = $urandom_range(0, 65535);
            b    = $urandom_range(0, 65535);
            if (mode == 1) b = a;
            else if (mode == 2) begin a = pick_operand(); b = pick_operand(); end
            else if (mode == 3) begin a = $urandom_range(0, 7); b = $urandom_range(0, 7); end
            do_op(code, a, b);
        end

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
